// File: rtl/delay_pkg.sv
// Shared definitions for the delay line: implementation selection and zero helper.
// Also carries the small DCT port typedefs used alongside rom_if.
package delay_pkg;

  typedef enum logic [1:0] {
    IMPL_PASS,
    IMPL_CHAIN,
    IMPL_RING
  } impl_e;

  localparam logic ZERO_BIT = 1'b0;

  typedef logic [9:0] dct_coef_t;
  typedef logic [2:0] dct_addr_t;

  // A single-stage line is always a register; the ring needs at least one entry.
  function automatic bit use_buffer(input int depth, input int srl_max);
    return (depth > srl_max) && (depth > 1);
  endfunction

  function automatic impl_e impl_sel(input int depth, input int srl_max);
    if (depth <= 0) return IMPL_PASS;
    if (use_buffer(depth, srl_max)) return IMPL_RING;
    return IMPL_CHAIN;
  endfunction

endpackage

// File: rtl/delay_if.sv
// Coefficient-ROM interface consumed by the DCT array; wires only, no logic.
interface rom_if #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int LANES      = 4
) ();

  logic [$clog2(DEPTH)-1:0] addr;
  logic                     en;
  logic [DATA_WIDTH-1:0]    data [LANES];

  modport tx (input addr, input en, output data);
  modport rx (output addr, output en, input data);

endinterface

// File: rtl/delay_ring_buf.sv
// Circular-buffer delay: DEPTH-1 entries plus a registered output stage.
// Memory is not reset; the fill counter keeps dout at zero until the line is primed.
module delay_ring_buf
  import delay_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int ENTRIES = DEPTH - 1;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int FW      = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] WP_LAST  = AW'(ENTRIES - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_RD  = FW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [AW-1:0]    r_wp;
  logic [FW-1:0]    r_fill;
  logic [WIDTH-1:0] r_dout;
  logic             w_primed;

  // The write happening on this edge is the DEPTH-th one, so the slot read now is real data.
  assign w_primed = (r_fill >= FILL_RD);

  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_mem[r_wp] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_dout <= {WIDTH{ZERO_BIT}};
    end else if (i_ce) begin
      r_dout <= w_primed ? r_mem[r_wp] : {WIDTH{ZERO_BIT}};
      r_wp   <= (r_wp == WP_LAST) ? '0 : r_wp + 1'b1;
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/delay.sv
// Fixed-latency delay line: dout is din from DEPTH (enabled) cycles earlier.
// Optional clock enable port ce is built when DELAY_CE_EN is defined.
module delay
  import delay_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 1,
  parameter int SRL_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DELAY_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam impl_e IMPL = impl_sel(DEPTH, SRL_MAX);

  logic w_ce;

`ifdef DELAY_CE_EN
  assign w_ce = ce;
`else
  assign w_ce = 1'b1;
`endif

  generate
    if (IMPL == IMPL_PASS) begin : g_pass
      assign dout = din;
    end else if (IMPL == IMPL_CHAIN) begin : g_chain
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= {WIDTH{ZERO_BIT}};
          end
        end else if (w_ce) begin
          r_stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign dout = r_stage[DEPTH-1];
    end else begin : g_ring
      delay_ring_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ce   (w_ce),
        .i_din  (din),
        .o_dout (dout)
      );
    end
  endgenerate

endmodule

// File: tb/tb_delay.sv
// Scoreboard bench for delay: several depths side by side against a history-array model,
// plus a rom_if loopback. Builds with or without DELAY_CE_EN.
module tb_delay;

  localparam int N = 8;
  localparam int DEP [N] = '{1, 3, 0, 20, 4, 18, 16, 2};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b1;

  logic [7:0]  d0 = '0, d4 = '0, d5 = '0, d6 = '0, d7 = '0;
  logic [10:0] d1 = '0;
  logic [3:0]  d2 = '0;
  logic        d3 = 1'b0;
  logic [7:0]  o0, o4, o5, o6, o7;
  logic [10:0] o1;
  logic [3:0]  o2;
  logic        o3;

  int n_vec = 0;
  int n_err = 0;
  int hist [N][1024];
  int cnt  [N];
  logic [N-1:0][31:0] sb [$];

  always #5 clk = ~clk;

  delay #(.WIDTH(8), .DEPTH(1)) u0 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d0), .dout(o0));
  delay #(.WIDTH(11), .DEPTH(3)) u1 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d1), .dout(o1));
  delay #(.WIDTH(4), .DEPTH(0)) u2 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d2), .dout(o2));
  delay #(.WIDTH(1), .DEPTH(20)) u3 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d3), .dout(o3));
  delay #(.WIDTH(8), .DEPTH(4)) u4 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d4), .dout(o4));
  delay #(.WIDTH(8), .DEPTH(18)) u5 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d5), .dout(o5));
  delay #(.WIDTH(8), .DEPTH(16)) u6 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d6), .dout(o6));
  delay #(.WIDTH(8), .DEPTH(2)) u7 (.clk(clk), .rst_n(rst_n),
`ifdef DELAY_CE_EN
    .ce(ce),
`endif
    .din(d7), .dout(o7));

  rom_if #(.DATA_WIDTH(10), .DEPTH(8), .LANES(4)) u_rom ();

  // Stand-in ROM on the tx side: lane j holds j+1 while enabled.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      u_rom.data[j] = u_rom.en ? 10'(j + 1) : 10'd0;
    end
  end

  function automatic int get_din(input int i);
    case (i)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      3: return int'(d3);
      4: return int'(d4);
      5: return int'(d5);
      6: return int'(d6);
      default: return int'(d7);
    endcase
  endfunction

  function automatic int get_dout(input int i);
    case (i)
      0: return int'(o0);
      1: return int'(o1);
      2: return int'(o2);
      3: return int'(o3);
      4: return int'(o4);
      5: return int'(o5);
      6: return int'(o6);
      default: return int'(o7);
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already set; predicts the next rising edge.
  task automatic apply(input logic rst_lvl);
    logic [N-1:0][31:0] e;
    logic was_high;
    was_high = rst_n;
    rst_n = rst_lvl;
    #1;
    check("pass_same_cycle", int'(o2), int'(d2));
    if (!rst_lvl && was_high) begin
      for (int i = 0; i < N; i++) begin
        if (DEP[i] > 0) check($sformatf("async_clear_u%0d", i), get_dout(i), 0);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rst_lvl) begin
        cnt[i] = 0;
      end else if (ce) begin
        hist[i][cnt[i]] = get_din(i);
        cnt[i]++;
      end
      if (DEP[i] == 0) e[i] = 32'(get_din(i));
      else if (cnt[i] >= DEP[i]) e[i] = 32'(hist[i][cnt[i] - DEP[i]]);
      else e[i] = 32'd0;
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    logic [N-1:0][31:0] e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < N; i++) begin
        check($sformatf("dout_u%0d_depth%0d", i, DEP[i]), get_dout(i), int'(e[i]));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) cnt[i] = 0;
    u_rom.addr = '0;
    u_rom.en   = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      apply(1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      d0 = (k == 0) ? 8'hA5 : 8'($urandom);
      d1 = 11'(k + 1);
      d2 = k[0] ? 4'hC : 4'h3;
      d3 = (k == 5);
      d4 = 8'hFF;
      d5 = 8'($urandom);
      d6 = 8'($urandom);
      d7 = 8'($urandom);
      ce = 1'b1;
      apply(1'b1);
    end

    @(negedge clk);
    apply(1'b0);

    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      d0 = 8'($urandom);
      d1 = 11'(k + 100);
      d2 = 4'($urandom);
      d3 = 1'($urandom_range(0, 1));
      d4 = (k < 20) ? 8'hFF : 8'($urandom);
      d5 = 8'($urandom);
      d6 = 8'($urandom);
      d7 = (k == 0) ? 8'h55 : ((k < 12) ? 8'h00 : 8'($urandom));
`ifdef DELAY_CE_EN
      ce = (k >= 1 && k <= 3) ? 1'b0 : ((k >= 12) ? ($urandom_range(0, 3) != 0) : 1'b1);
`else
      ce = 1'b1;
`endif
      apply(1'b1);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    u_rom.addr = 3'd2;
    u_rom.en   = 1'b1;
    #1;
    check("rom_rx_data2_en", int'(u_rom.data[2]), 3);
    check("rom_rx_data0_en", int'(u_rom.data[0]), 1);
    u_rom.en = 1'b0;
    #1;
    check("rom_rx_data2_off", int'(u_rom.data[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
